// File: rtl/ripple_borrow_subtractor.sv
// ripple_borrow_subtractor
//
// Pipelined bit-sliced ripple-borrow subtractor. It computes
// {bout, diff} = {1'b0, a} - {1'b0, b} - bin. One bit slice is evaluated
// per clock stage, and the borrow advances one slice per cycle. A new
// operand pair can enter on every cycle. The aligned result appears WIDTH
// edges after the edge that samples the operands.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every register
//   in_valid   operand pair present this cycle
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  diff/bout hold a completed result this cycle
//   diff       (a - b - bin) mod 2^WIDTH, held between results
//   bout       borrow out (1 iff a < b + bin), held between results
//
// Valid/ready semantics: there is no ready. Every cycle with in_valid=1 is
// accepted. Each accepted operation produces exactly one out_valid=1 cycle.
// Each idle cycle produces exactly one out_valid=0 cycle. Order is
// preserved, and the consumer must take every result.
//
// Stage k register contents:
//   - operand bits k..WIDTH-1, which form the input skew;
//   - the borrow entering slice k;
//   - diff bits 0..k-1 already produced, which form the output deskew.
// Slice k reads its operand bits and its borrow, and its result is
// registered into stage k+1. Slice WIDTH-1 feeds the output registers.
// Operand bits below k and diff bits at or above k in stage k are not
// used by the datapath.
module ripple_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Valid token per stage. A stage's data loads only with a valid token,
  // so idle cycles leave the pipeline data untouched.
  logic [WIDTH-1:0] v;

  logic [WIDTH-1:0] a_s  [WIDTH];
  logic [WIDTH-1:0] b_s  [WIDTH];
  logic [WIDTH-1:0] d_s  [WIDTH];
  logic [WIDTH-1:0] br_s;

  // Result of slice k: the diff vector with bit k filled in, and the borrow
  // passed to slice k+1.
  logic [WIDTH-1:0] d_nxt [WIDTH];
  logic [WIDTH-1:0] br_nxt;

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      d_nxt[k]    = d_s[k];
      d_nxt[k][k] = a_s[k][k] ^ b_s[k][k] ^ br_s[k];
      br_nxt[k]   = (~a_s[k][k] & b_s[k][k]) |
                    (~(a_s[k][k] ^ b_s[k][k]) & br_s[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= '0;
      br_s      <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
        a_s[k] <= '0;
        b_s[k] <= '0;
        d_s[k] <= '0;
      end
    end else begin
      v         <= {v[WIDTH-2:0], in_valid};
      out_valid <= v[WIDTH-1];

      // Stage 0 captures the full operands. bin is the borrow into slice 0.
      if (in_valid) begin
        a_s[0]  <= a;
        b_s[0]  <= b;
        d_s[0]  <= '0;
        br_s[0] <= bin;
      end

      for (int k = 1; k < WIDTH; k++) begin
        if (v[k-1]) begin
          a_s[k]  <= a_s[k-1];
          b_s[k]  <= b_s[k-1];
          d_s[k]  <= d_nxt[k-1];
          br_s[k] <= br_nxt[k-1];
        end
      end

      // The last slice finishes the diff and produces the final borrow.
      // Both hold while no result is delivered.
      if (v[WIDTH-1]) begin
        diff <= d_nxt[WIDTH-1];
        bout <= br_nxt[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_ripple_borrow_subtractor.sv
// Self-checking bench for ripple_borrow_subtractor.
// WIDTH=4 instance: directed tests.
// WIDTH=2 and WIDTH=16 instances: random streams.
module tb_ripple_borrow_subtractor;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / check ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- main WIDTH=4 DUT ----------------
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic [W-1:0] diff;
  logic         bout;

  ripple_borrow_subtractor #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .diff(diff), .bout(bout)
  );

  // Scoreboard: expected {bout, diff} and the edge that sampled the operands.
  logic [W:0] exp_q[$];
  int         iss_q[$];
  logic [W:0] last_res = '0;

  function automatic logic [W:0] model4(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - (W+1)'(c);
  endfunction

  // Driver tasks. They drive at negedge, and the next posedge samples.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic [W:0] e);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; bin = c;
    exp_q.push_back(e);
    iss_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
  endtask

  // Monitor: checks output values, exact latency, and hold during bubbles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("w4_spurious_out_valid", 1, 0);
        end else begin
          logic [W:0] e;
          int         s;
          e = exp_q.pop_front();
          s = iss_q.pop_front();
          chk("w4_result", {bout, diff}, e);
          chk("w4_latency", cyc - s, W);
        end
        last_res = {bout, diff};
      end else begin
        chk("w4_hold", {bout, diff}, last_res);
      end
    end
  end

  // ---------------- WIDTH sweep instances ----------------
  logic sweep_go = 1'b0;
  logic [1:0] sweep_done = 2'b00;

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 2 : 16;
    logic          s_iv;
    logic [SW-1:0] s_a, s_b, s_d;
    logic          s_bin, s_ov, s_bo;
    logic [SW:0]   s_q[$];
    int            s_iss[$];

    ripple_borrow_subtractor #(.WIDTH(SW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .a(s_a), .b(s_b), .bin(s_bin),
      .out_valid(s_ov), .diff(s_d), .bout(s_bo)
    );

    initial begin
      s_iv = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 10000; i++) begin
        @(negedge clk);
        s_iv  = ($urandom_range(0, 7) != 0);
        s_a   = SW'($urandom);
        s_b   = SW'($urandom);
        s_bin = 1'($urandom);
        if (s_iv) begin
          s_q.push_back({1'b0, s_a} - {1'b0, s_b} - (SW+1)'(s_bin));
          s_iss.push_back(cyc + 1);
        end
      end
      @(negedge clk);
      s_iv = 1'b0;
      repeat (SW + 3) @(negedge clk);
      chk("sweep_drained", s_q.size(), 0);
      sweep_done[g] = 1'b1;
    end

    always @(negedge clk) begin
      if (rst_n && s_ov) begin
        if (s_q.size() == 0) begin
          chk("sweep_spurious_out_valid", 1, 0);
        end else begin
          logic [SW:0] e;
          int          s;
          e = s_q.pop_front();
          s = s_iss.pop_front();
          chk("sweep_result", {s_bo, s_d}, e);
          chk("sweep_latency", cyc - s, SW);
        end
      end
    end
  end

  // ---------------- directed test ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{a: 4'd9,  b: 4'd4,  bin: 1'b0, d: 4'd5,  bo: 1'b0};
    tbl[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, d: 4'd14, bo: 1'b1};
    tbl[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'd15, bo: 1'b1};
    tbl[3] = '{a: 4'd15, b: 4'd15, bin: 1'b1, d: 4'd15, bo: 1'b1};
    tbl[4] = '{a: 4'd8,  b: 4'd0,  bin: 1'b1, d: 4'd7,  bo: 1'b0};
    tbl[5] = '{a: 4'd6,  b: 4'd6,  bin: 1'b0, d: 4'd0,  bo: 1'b0};
    tbl[6] = '{a: 4'd10, b: 4'd3,  bin: 1'b1, d: 4'd6,  bo: 1'b0};
    tbl[7] = '{a: 4'd0,  b: 4'd1,  bin: 1'b0, d: 4'd15, bo: 1'b1};

    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset state
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ops from the table, isolated by idle cycles
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].bin, {tbl[i].bo, tbl[i].d});
      idle(W + 2);
    end

    // Streaming: all 512 combinations back to back
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          issue(W'(x), W'(y), 1'(c), model4(W'(x), W'(y), 1'(c)));
    idle(W + 2);

    // Bubbles with random don't-care operands: valid, idle, idle, valid
    issue(4'd12, 4'd5, 1'b0, {1'b0, 4'd7});
    idle(2);
    issue(4'd2, 4'd9, 1'b1, {1'b1, 4'd8});
    idle(W + 3);

    // Reset mid-flight: three ops in flight, reset pulse between edges
    issue(4'd7, 4'd2, 1'b0, model4(4'd7, 4'd2, 1'b0));
    issue(4'd1, 4'd4, 1'b1, model4(4'd1, 4'd4, 1'b1));
    issue(4'd13, 4'd13, 1'b0, model4(4'd13, 4'd13, 1'b0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_diff", diff, 0);
    chk("midreset_bout", bout, 0);
    exp_q.delete();
    iss_q.delete();
    last_res = '0;
    #1 rst_n = 1'b1;
    idle(2 * W);
    issue(4'd11, 4'd6, 1'b1, {1'b0, 4'd4});
    idle(W + 3);
    chk("w4_drained", exp_q.size(), 0);

    // Width sweep
    sweep_go = 1'b1;
    for (int i = 0; i < 15000 && sweep_done != 2'b11; i++) @(negedge clk);
    chk("sweep_finished", sweep_done, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
